// File: rtl/ro_pair_evaluator.sv
// ---------------------------------------------------------------------------
// ro_pair_evaluator
//
// Sequencer and comparator for the ring-oscillator PUF. For each pair k it
// selects RO k on mux A and RO k+8 on mux B, lets the muxes settle, counts
// rising edges on both mux outputs over a fixed window, and stores
// (count_a > count_b) as response bit k. Once all NBITS pairs are evaluated
// it pulses done and holds the response word with valid high.
//
// Parameters
//   NBITS   response bits per run (1..8); bit k compares RO k vs RO k+8
//   CNT_W   edge-counter width; counters saturate at 2^CNT_W-1
//   SETTLE  clk cycles after a select change before counting (>=2)
//   WINDOW  clk cycles of edge counting per pair (>=1)
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   request a new evaluation, sampled only in IDLE
//   ro_a      in   mux A output, asynchronous to clk
//   ro_b      in   mux B output, asynchronous to clk
//   sel_a     out  [0:3] select for mux A
//   sel_b     out  [0:3] select for mux B
//   ro_en     out  ring-oscillator enable (first SETTLE .. last COMPARE)
//   busy      out  high whenever the FSM is not in IDLE
//   done      out  one-cycle pulse when a run completes
//   valid     out  response holds a complete result
//   response  out  [NBITS-1:0] response word, bit k = pair k
// ---------------------------------------------------------------------------
module ro_pair_evaluator #(
  parameter int NBITS  = 8,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 8,
  parameter int WINDOW = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic [0:3]       sel_a,
  output logic [0:3]       sel_b,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [NBITS-1:0] response
);

  // One shared phase timer covers both the SETTLE and COUNT intervals.
  localparam int TMR_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [2:0]       LAST_IDX    = 3'(NBITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_COMPARE,
    ST_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [TMR_W-1:0]   r_tmr;
  logic [2:0]         r_idx;
  logic [2:0]         w_idx_next;
  logic [3:0]         r_sel_a;
  logic [3:0]         r_sel_b;
  logic [NBITS-1:0]   r_resp;
  logic [NBITS-1:0]   w_resp_next;
  logic               r_valid;

  logic [1:0]         w_ro_in;
  logic [CNT_W-1:0]   w_cnt [2];
  logic               w_clr_cnt;
  logic               w_cnt_en;
  logic               w_a_gt_b;
  logic               w_start_ok;
  logic               w_enter_settle;

  genvar gi;

  // Channel 0 is mux A, channel 1 is mux B.
  assign w_ro_in   = {ro_b, ro_a};
  assign w_clr_cnt = (r_state == ST_SETTLE);
  assign w_cnt_en  = (r_state == ST_COUNT);

  // -------------------------------------------------------------------------
  // Per-channel synchronizer, edge detector and saturating edge counter.
  // r_sync[0] and r_sync[1] form the 2-flop synchronizer; r_sync[2] is the
  // delayed copy used for rising-edge detection. Counters are held at zero
  // through SETTLE, so edges from the previous pair that are still in the
  // pipeline never reach the next count.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [2:0]       r_sync;
      logic [CNT_W-1:0] r_cnt;
      logic             w_edge;

      assign w_edge = r_sync[1] & ~r_sync[2];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= '0;
          r_cnt  <= '0;
        end else begin
          r_sync <= {r_sync[1:0], w_ro_in[gi]};
          if (w_clr_cnt) begin
            r_cnt <= '0;
          end else if (w_cnt_en && w_edge && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  // A tie yields 0.
  assign w_a_gt_b = (w_cnt[0] > w_cnt[1]);

  // -------------------------------------------------------------------------
  // FSM next-state logic.
  // -------------------------------------------------------------------------
  assign w_start_ok = (r_state == ST_IDLE) && start;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_tmr == SETTLE_LAST) begin
          w_state_next = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (r_tmr == WINDOW_LAST) begin
          w_state_next = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_SETTLE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_enter_settle = (w_state_next == ST_SETTLE) && (r_state != ST_SETTLE);

  // Pair index: restarts at 0 on an accepted start, advances when COMPARE
  // hands over to the next pair.
  always_comb begin
    w_idx_next = r_idx;
    if (w_start_ok) begin
      w_idx_next = 3'd0;
    end else if ((r_state == ST_COMPARE) && (w_state_next == ST_SETTLE)) begin
      w_idx_next = r_idx + 3'd1;
    end
  end

  // Response bit k is written only in the COMPARE cycle of pair k.
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_resp
      assign w_resp_next[gi] = ((r_state == ST_COMPARE) && (r_idx == 3'(gi)))
                               ? w_a_gt_b : r_resp[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State and datapath registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_idx   <= 3'd0;
      r_sel_a <= 4'd0;
      r_sel_b <= 4'd0;
      r_resp  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;

      // Timer restarts on every state change so each phase counts from 0.
      if (w_state_next != r_state) begin
        r_tmr <= '0;
      end else if ((r_state == ST_SETTLE) || (r_state == ST_COUNT)) begin
        r_tmr <= r_tmr + 1'b1;
      end

      // Selects only move on SETTLE entry, so they keep the last pair's
      // value through DONE and IDLE.
      if (w_enter_settle) begin
        r_sel_a <= {1'b0, w_idx_next};
        r_sel_b <= {1'b1, w_idx_next};
      end

      if (w_start_ok) begin
        r_resp  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_resp <= w_resp_next;
        if (w_state_next == ST_DONE) begin
          r_valid <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs decoded from registered state.
  // -------------------------------------------------------------------------
  assign sel_a    = r_sel_a;
  assign sel_b    = r_sel_b;
  assign ro_en    = (r_state == ST_SETTLE) || (r_state == ST_COUNT) ||
                    (r_state == ST_COMPARE);
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign valid    = r_valid;
  assign response = r_resp;

endmodule

// File: tb/tb_ro_pair_evaluator.sv
module tb_ro_pair_evaluator;

  localparam int S    = 4;
  localparam int W    = 64;
  localparam int PAIR = S + W + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, start1, start2;

  int cyc  = 0;   // advances on posedge: value at a negedge is the current cycle
  int rcyc = 0;   // drives the RO waveforms away from the sampling edge
  always @(posedge clk) cyc  <= cyc + 1;
  always @(negedge clk) rcyc <= rcyc + 1;

  // Oscillation period (in clk cycles) of each of the 16 ROs behind the muxes.
  int per_tab [16];

  function automatic logic wave(input int p, input int c);
    if (p < 2) return 1'b0;
    return ((c % p) < (p / 2));
  endfunction

  // DUT0: main configuration; DUT1: 3-bit saturating counters; DUT2: NBITS=1.
  logic [0:3] sel_a0, sel_b0, sel_a1, sel_b1, sel_a2, sel_b2;
  logic       ro_a0, ro_b0, ro_a1, ro_b1, ro_a2, ro_b2;
  logic       ro_en0, busy0, done0, valid0;
  logic       ro_en1, busy1, done1, valid1;
  logic       ro_en2, busy2, done2, valid2;
  logic [7:0] response0, response1;
  logic [0:0] response2;

  assign ro_a0 = wave(per_tab[sel_a0], rcyc);
  assign ro_b0 = wave(per_tab[sel_b0], rcyc);
  assign ro_a1 = wave(per_tab[sel_a1], rcyc);
  assign ro_b1 = wave(per_tab[sel_b1], rcyc);
  assign ro_a2 = wave(per_tab[sel_a2], rcyc);
  assign ro_b2 = wave(per_tab[sel_b2], rcyc);

  ro_pair_evaluator #(.NBITS(8), .CNT_W(16), .SETTLE(S), .WINDOW(W)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .ro_a(ro_a0), .ro_b(ro_b0),
    .sel_a(sel_a0), .sel_b(sel_b0), .ro_en(ro_en0), .busy(busy0),
    .done(done0), .valid(valid0), .response(response0));

  ro_pair_evaluator #(.NBITS(8), .CNT_W(3), .SETTLE(S), .WINDOW(W)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .ro_a(ro_a1), .ro_b(ro_b1),
    .sel_a(sel_a1), .sel_b(sel_b1), .ro_en(ro_en1), .busy(busy1),
    .done(done1), .valid(valid1), .response(response1));

  ro_pair_evaluator #(.NBITS(1), .CNT_W(16), .SETTLE(S), .WINDOW(W)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .ro_a(ro_a2), .ro_b(ro_b2),
    .sel_a(sel_a2), .sel_b(sel_b2), .ro_en(ro_en2), .busy(busy2),
    .done(done2), .valid(valid2), .response(response2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // -------------------------------------------------------------------------
  // Scoreboard: expected (response, done cycle) pushed at stimulus time.
  // -------------------------------------------------------------------------
  typedef struct {
    logic [7:0] resp;
    int         cyc;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  task automatic score(input int id, input logic [7:0] resp, input logic vld);
    exp_t e;
    int   n;
    n = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_unexpected_done actual=done required=no_done (cycle %0d)", id, cyc);
      return;
    end
    case (id)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    $display("dut%0d done cycle=%0d response=%02h valid=%0b", id, cyc, resp, vld);
    chk($sformatf("dut%0d_response", id), 32'(resp), 32'(e.resp));
    chk($sformatf("dut%0d_done_cycle", id), 32'(cyc), 32'(e.cyc));
    chk($sformatf("dut%0d_valid_at_done", id), 32'(vld), 32'd1);
  endtask

  always @(negedge clk) begin
    if (done0) score(0, response0, valid0);
    if (done1) score(1, response1, valid1);
    if (done2) score(2, {7'd0, response2}, valid2);
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers.
  // -------------------------------------------------------------------------
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic launch(input bit g0, input bit g1, input bit g2, input bit push,
                        input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                        output int t);
    exp_t e;
    @(negedge clk);
    t      = cyc;
    start0 = g0;
    start1 = g1;
    start2 = g2;
    if (push) begin
      if (g0) begin e.resp = e0; e.cyc = t + 1 + 8 * PAIR; q0.push_back(e); end
      if (g1) begin e.resp = e1; e.cyc = t + 1 + 8 * PAIR; q1.push_back(e); end
      if (g2) begin e.resp = e2; e.cyc = t + 1 + PAIR;     q2.push_back(e); end
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic pulse_start0(input int c);
    wait_until(c);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic set_split(input int pa, input int pb);
    for (int i = 0; i < 8; i++) begin
      per_tab[i]     = pa;
      per_tab[i + 8] = pb;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int seen;

    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    set_split(4, 6);

    // 1. Reset with ROs toggling, then 100 idle cycles without start.
    repeat (3) @(negedge clk);
    chk("rst_sel_a",    32'(sel_a0),    32'd0);
    chk("rst_sel_b",    32'(sel_b0),    32'd0);
    chk("rst_ro_en",    32'(ro_en0),    32'd0);
    chk("rst_busy",     32'(busy0),     32'd0);
    chk("rst_done",     32'(done0),     32'd0);
    chk("rst_valid",    32'(valid0),    32'd0);
    chk("rst_response", 32'(response0), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (done0 | done1 | done2 | busy0 | busy1 | busy2) seen++;
    end
    chk("idle_no_activity", 32'(seen), 32'd0);

    // 2. Throughput: A period 4, B period 8, plus ignored start pulses
    //    at t+10 and t+300 on DUT0.
    set_split(4, 8);
    launch(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h01, t);
    chk("busy_t+1",  32'(busy0),  32'd1);
    chk("valid_t+1", 32'(valid0), 32'd0);
    chk("ro_en_t+1", 32'(ro_en0), 32'd1);
    for (int k = 0; k < 8; k++) begin
      wait_until(t + 1 + k * PAIR + 2);
      chk($sformatf("sel_a_pair%0d", k), 32'(sel_a0), 32'(k));
      chk($sformatf("sel_b_pair%0d", k), 32'(sel_b0), 32'(k + 8));
      if (k == 0) pulse_start0(t + 10);
      if (k == 4) pulse_start0(t + 300);
    end
    wait_until(t + 8 * PAIR);
    chk("ro_en_last_compare", 32'(ro_en0), 32'd1);
    wait_until(t + 1 + 8 * PAIR);
    chk("ro_en_at_done", 32'(ro_en0), 32'd0);
    wait_until(t + 4 + 8 * PAIR);
    chk("idle_busy",     32'(busy0),     32'd0);
    chk("idle_valid",    32'(valid0),    32'd1);
    chk("idle_response", 32'(response0), 32'hFF);
    chk("idle_sel_a",    32'(sel_a0),    32'd7);
    chk("idle_sel_b",    32'(sel_b0),    32'd15);
    chk("nb1_sel_a",     32'(sel_a2),    32'd0);
    chk("nb1_sel_b",     32'(sel_b2),    32'd8);
    chk("nb1_valid",     32'(valid2),    32'd1);

    // 3. Alternating pattern: A faster on even pairs, B faster on odd pairs.
    for (int i = 0; i < 8; i++) begin
      per_tab[i]     = (i % 2 == 0) ? 4 : 8;
      per_tab[i + 8] = (i % 2 == 0) ? 8 : 4;
    end
    launch(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h00, 8'h01, t);
    chk("pattern_valid_cleared", 32'(valid0), 32'd0);
    wait_until(t + 4 + 8 * PAIR);

    // 4. Tie: equal periods everywhere.
    set_split(4, 4);
    launch(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, t);
    wait_until(t + 4 + 8 * PAIR);

    // 5. Abort with rst mid-run, then a full clean run.
    set_split(4, 8);
    launch(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, t);
    wait_until(t + 100);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy",     32'(busy0),     32'd0);
    chk("abort_ro_en",    32'(ro_en0),    32'd0);
    chk("abort_valid",    32'(valid0),    32'd0);
    chk("abort_response", 32'(response0), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    launch(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, t);
    wait_until(t + 4 + 8 * PAIR);
    chk("rerun_valid", 32'(valid0), 32'd1);

    repeat (10) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_pair_evaluator.md
Name: ro_pair_evaluator

Overview:
Sequencer and comparator for the ring-oscillator PUF. Drives the select inputs of two 16:1 RO selection muxes and counts rising edges on each mux output over a fixed window. It derives one response bit per RO pair and assembles an NBITS-wide response word for the AES key-generation path.

Parameters:
NBITS, 8, response bits produced per run (1..8); bit k compares RO k against RO k+8
CNT_W, 16, edge-counter width; counters saturate at 2^CNT_W-1
SETTLE, 8, clk cycles after a select change before counting starts (>=2)
WINDOW, 1024, clk cycles of edge counting per pair (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new evaluation; sampled only in IDLE
ro_a  input  1  output of mux A (asynchronous to clk)
ro_b  input  1  output of mux B (asynchronous to clk)
sel_a  output  [0:3]  select for mux A
sel_b  output  [0:3]  select for mux B
ro_en  output  1  ring-oscillator enable
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, run complete
valid  output  1  response holds a complete result
response  output  NBITS  response word; bit k = pair k

Behaviour:
- Reset (synchronous, any state): state=IDLE. sel_a=0, sel_b=0, ro_en=0, busy=0, done=0, valid=0, response=0. Counters, index and synchronizers cleared.
- ro_a/ro_b each pass through a 2-flop synchronizer, then a rising-edge detector (sync_q1 & ~sync_q2).
- FSM states: IDLE, SETTLE, COUNT, COMPARE, DONE.
- IDLE: start=1 at cycle t -> SETTLE at t+1. Index k=0, response=0, valid=0.
- SETTLE: sel_a=k, sel_b=k+8, ro_en=1. Both edge counters held at 0. Stays for exactly SETTLE cycles, then COUNT.
- COUNT: lasts exactly WINDOW cycles. Each counter increments on its detected edge and saturates at 2^CNT_W-1 (no wrap).
- COMPARE: 1 cycle. response[k] = (cnt_a > cnt_b); a tie gives 0.
  - If k < NBITS-1: k=k+1 -> SETTLE.
  - Else -> DONE.
- DONE: 1 cycle. done=1, valid=1, ro_en=0, then IDLE.
- valid stays high until the next accepted start or reset. response stays stable in IDLE.
- sel_a/sel_b keep the last pair's value in IDLE and DONE; they change only on entry to SETTLE.
- ro_en is 1 from the first SETTLE through the last COMPARE, and 0 otherwise.
- Latency: done is high in cycle t + 1 + NBITS*(SETTLE+WINDOW+1).
- start while busy is ignored (no restart, no queuing). start in the same cycle as rst: rst wins.
- rst mid-run aborts immediately. The next start runs a full evaluation from k=0.
- Edges still in the synchronizer at the end of COUNT are discarded. Counters are cleared on every SETTLE entry.

Test Plan:
1. Reset: assert rst 3 cycles with ro toggling -> all outputs 0. No done for 100 cycles without start.
2. Throughput (NBITS=8, SETTLE=4, WINDOW=64, CNT_W=16):
   - Stimulus: ro_a period 4 clk, ro_b period 8 clk, start pulse at t.
   - Required: busy at t+1; sel_a=k, sel_b=k+8 during pair k; done exactly at t+553; response=8'hFF; valid=1; per-pair counts 16 vs 8 (±1).
3. Pattern: ro_a faster for even k, ro_b faster for odd k (sel-dependent RO model) -> response=8'h55.
4. Tie and saturation:
   - Equal 4-clk periods on both -> response=8'h00.
   - CNT_W=3 with periods 4 and 8 -> both saturate at 7 -> response=8'h00.
5. Control:
   - start pulses at t+10 and t+300 during a run -> single done at t+553, no restart.
   - rst at t+100 -> busy=0, ro_en=0, valid=0 next cycle; a subsequent start completes with the correct response.
6. NBITS=1 -> only sel_a=0, sel_b=8 is used; done at t+1+(SETTLE+WINDOW+1); response[0] correct.
